// File: rtl/rot_arb_pkg.sv
// Shared constants, response-state encoding and the clog2 helper for the rotate arbiter.
package rot_arb_pkg;

  localparam logic ROT_LEFT  = 1'b1;
  localparam logic ROT_RIGHT = 1'b0;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rotate_core.sv
// Combinational log-stage rotator: stage s rotates by 2^s when amt[s] is set.
// Zero latency, no state; direction taken from lr (ROT_LEFT / ROT_RIGHT).
module rotate_core
  import rot_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] data,
  input  logic             lr,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stg [0:SHW];

  assign stg[0] = data;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int SH = 1 << s;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] ror;

    assign rol = {stg[s][WIDTH-1-SH:0], stg[s][WIDTH-1:WIDTH-SH]};
    assign ror = {stg[s][SH-1:0], stg[s][WIDTH-1:SH]};

    assign stg[s+1] = !amt[s]         ? stg[s] :
                      (lr == ROT_LEFT) ? rol    : ror;
  end

  assign out = stg[SHW];

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin share of one rotate_core among NREQ valid/ready requesters; 1-cycle registered response.
// A held response (rsp_valid & !rsp_ready) blocks all grants and freezes the round-robin pointer.
module rotate_arbiter
  import rot_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = clog2(WIDTH),
  parameter int IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_lr,
  input  logic [NREQ*SHW-1:0]   req_amt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  rsp_state_e       state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [WIDTH-1:0] rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;

  logic             can_acc;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic             xfer;

  logic [WIDTH-1:0] sel_data;
  logic             sel_lr;
  logic [SHW-1:0]   sel_amt;
  logic [WIDTH-1:0] rot_data;

  assign rsp_valid = (state_q == ST_FULL);
  assign can_acc   = !rsp_valid | rsp_ready;
  assign xfer      = gnt_vld & can_acc & !rst;

  // Search from rr_ptr upwards, wrapping; the first valid requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign sel_data = req_data[gnt_idx*WIDTH +: WIDTH];
  assign sel_lr   = req_lr[gnt_idx];
  assign sel_amt  = req_amt[gnt_idx*SHW +: SHW];

  rotate_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_rotate_core (
    .data (sel_data),
    .lr   (sel_lr),
    .amt  (sel_amt),
    .out  (rot_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      case (state_q)
        ST_EMPTY: if (xfer) state_q <= ST_FULL;
        ST_FULL:  if (!xfer && rsp_ready) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
      if (xfer) begin
        rsp_data_q <= rot_data;
        rsp_id_q   <= gnt_idx;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;
  assign busy     = rsp_valid & !rsp_ready;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench for rotate_arbiter: grant order, stall, reset and an exhaustive rotate sweep.
module tb_rotate_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_lr;
  logic [NREQ*SHW-1:0]   req_amt;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  int n_checks;
  int n_errors;

  rotate_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .SHW   (SHW),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_lr    (req_lr),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic lr, input int k);
    logic [7:0] o;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      if (lr) o[(j + k) % 8] = d[j];
      else    o[j] = d[(j + k) % 8];
    end
    return o;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_data  = '0;
    req_lr    = '0;
    req_amt   = '0;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic lr, input logic [2:0] amt);
    req_valid[i]              = 1'b1;
    req_data[i*WIDTH +: WIDTH] = d;
    req_lr[i]                 = lr;
    req_amt[i*SHW +: SHW]      = amt;
  endtask

  initial begin
    logic [11:0] v;
    logic [11:0] pv;
    int          id;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h55, 1'b1, 3'd1);

    // Reset state, with every request asserted.
    next_cycle();
    next_cycle();
    sample();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request: 0xCC rotate left by 1.
    next_cycle();
    rst = 1'b0;
    clear_reqs();
    set_req(0, 8'hCC, 1'b1, 3'd1);
    sample();
    check("t1_req_ready", 32'(req_ready), 32'b0001);
    check("t1_pre_valid", 32'(rsp_valid), 32'd0);

    // Pointer now at 1: req0 and req1 compete, req1 must win.
    next_cycle();
    clear_reqs();
    set_req(0, 8'h77, 1'b0, 3'd0);
    set_req(1, 8'hA5, 1'b0, 3'd0);
    sample();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data",  32'(rsp_data),  32'h99);
    check("t1_rsp_id",    32'(rsp_id),    32'd0);
    check("ptr1_grant",   32'(req_ready), 32'b0010);

    // Right rotate by 3 through req2.
    next_cycle();
    clear_reqs();
    set_req(2, 8'hF0, 1'b0, 3'd3);
    sample();
    check("ptr1_rsp_id",   32'(rsp_id),    32'd1);
    check("ptr1_rsp_data", 32'(rsp_data),  32'hA5);
    check("t2_req_ready",  32'(req_ready), 32'b0100);

    next_cycle();
    clear_reqs();
    set_req(3, 8'h81, 1'b1, 3'd4);
    sample();
    check("t2_rsp_id",    32'(rsp_id),    32'd2);
    check("t2_rsp_data",  32'(rsp_data),  32'h1E);
    check("t3_req_ready", 32'(req_ready), 32'b1000);

    // Fairness: all four held valid for 8 cycles, amt=0 so data echoes.
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      clear_reqs();
      if (c < 8) begin
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h11 * (i + 1)), 1'b1, 3'd0);
      end
      sample();
      if (c == 0) begin
        check("t3_rsp_id",   32'(rsp_id),   32'd3);
        check("t3_rsp_data", 32'(rsp_data), 32'h18);
      end else begin
        id = (c - 1) % 4;
        check($sformatf("fair%0d_valid", c), 32'(rsp_valid), 32'd1);
        check($sformatf("fair%0d_id", c),    32'(rsp_id),    32'(id));
        check($sformatf("fair%0d_data", c),  32'(rsp_data),  32'(8'h11 * (id + 1)));
      end
      if (c < 8) check($sformatf("fair%0d_grant", c), 32'(req_ready), 32'(1 << (c % 4)));
    end

    // Backpressure: load a response from req0, then stall with req1 and req3 pending.
    next_cycle();
    clear_reqs();
    rsp_ready = 1'b0;
    set_req(0, 8'h0F, 1'b0, 3'd0);
    sample();
    check("retire_valid", 32'(rsp_valid), 32'd0);
    check("bp_load_grant", 32'(req_ready), 32'b0001);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      clear_reqs();
      set_req(1, 8'h5A, 1'b1, 3'd2);
      set_req(3, 8'h3C, 1'b1, 3'd3);
      sample();
      check($sformatf("bp%0d_busy", c),  32'(busy),      32'd1);
      check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d_data", c),  32'(rsp_data),  32'h0F);
      check($sformatf("bp%0d_id", c),    32'(rsp_id),    32'd0);
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
    end
    next_cycle();
    rsp_ready = 1'b1;
    sample();
    check("rel_busy",  32'(busy),      32'd0);
    check("rel_grant", 32'(req_ready), 32'b0010);

    next_cycle();
    clear_reqs();
    set_req(3, 8'h3C, 1'b1, 3'd3);
    sample();
    check("rel_req1_id",   32'(rsp_id),    32'd1);
    check("rel_req1_data", 32'(rsp_data),  32'h69);
    check("rel_grant3",    32'(req_ready), 32'b1000);

    next_cycle();
    clear_reqs();
    set_req(1, 8'h5A, 1'b1, 3'd2);
    sample();
    check("rel_req3_id",   32'(rsp_id),    32'd3);
    check("rel_req3_data", 32'(rsp_data),  32'hE1);
    check("pre_rst_grant", 32'(req_ready), 32'b0010);

    // Stall with the pointer at 2, then reset mid-stall.
    next_cycle();
    clear_reqs();
    rsp_ready = 1'b0;
    sample();
    check("stall2_busy", 32'(busy),   32'd1);
    check("stall2_id",   32'(rsp_id), 32'd1);

    next_cycle();
    rst = 1'b1;
    set_req(1, 8'h24, 1'b1, 3'd1);
    set_req(2, 8'h42, 1'b1, 3'd1);
    sample();
    check("rst_mid_ready", 32'(req_ready), 32'd0);

    next_cycle();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    sample();
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_data",  32'(rsp_data),  32'd0);
    check("rst_mid_id",    32'(rsp_id),    32'd0);
    check("rst_mid_busy",  32'(busy),      32'd0);
    check("rst_mid_ptr0",  32'(req_ready), 32'b0010);

    next_cycle();
    clear_reqs();
    sample();
    check("post_rst_id",   32'(rsp_id),   32'd1);
    check("post_rst_data", 32'(rsp_data), 32'h48);

    // Exhaustive rotate sweep through req0, one op per cycle.
    pv = '0;
    for (int n = 0; n <= 4096; n++) begin
      v = 12'(n);
      next_cycle();
      clear_reqs();
      if (n < 4096) set_req(0, v[7:0], v[11], v[10:8]);
      sample();
      if (n > 0) begin
        check($sformatf("sweep_d%0h_lr%0d_a%0d", pv[7:0], pv[11], pv[10:8]),
              32'(rsp_data), 32'(rot_ref(pv[7:0], pv[11], int'(pv[10:8]))));
      end
      pv = v;
    end

    next_cycle();
    sample();
    check("final_idle_valid", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
